// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP word, default reset PC
// and the alignment helper used by the fetch path.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'd0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // A fetch target is usable only when it is word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_npc_unit.sv
// PC / nPC pair with a one-entry pending redirect. A redirect that arrives
// while nPC is stalled is parked and applied on the next nPC load. A
// misaligned effective target raises misalign_trap and freezes all state.
module pc_npc_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        pc_le,
  input  logic        npc_le,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        misalign_trap
);

  logic [31:0] pc_r;
  logic [31:0] npc_r;
  logic [31:0] pend_target_r;
  logic        pend_r;

  logic        redirect_s;
  logic [31:0] eff_target_s;
  logic        trap_s;

  // Pick the redirect target for this cycle (live branch beats the parked one)
  always_comb begin
    redirect_s   = 1'b0;
    eff_target_s = pend_target_r;
    if (branch_taken) begin
      redirect_s   = 1'b1;
      eff_target_s = branch_target;
    end else if (pend_r) begin
      redirect_s   = 1'b1;
      eff_target_s = pend_target_r;
    end else begin
      redirect_s   = 1'b0;
      eff_target_s = pend_target_r;
    end
    trap_s = run_en & redirect_s & is_misaligned(eff_target_s);
  end

  // PC, nPC and pending-redirect registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r          <= RESET_PC;
      npc_r         <= RESET_PC + INSTR_BYTES;
      pend_r        <= 1'b0;
      pend_target_r <= 32'd0;
    end else if (run_en && !trap_s) begin
      if (pc_le) begin
        pc_r <= npc_r;
      end
      if (npc_le) begin
        npc_r  <= redirect_s ? eff_target_s : (npc_r + INSTR_BYTES);
        pend_r <= 1'b0;
      end else if (branch_taken) begin
        pend_r        <= 1'b1;
        pend_target_r <= branch_target;
      end
    end
  end

  assign pc            = pc_r;
  assign npc           = npc_r;
  assign misalign_trap = trap_s;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: START/RUN/HALT control, the IF/ID pipeline
// register and the count of valid instructions handed to decode.
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_le,
  input  logic              npc_le,
  input  logic              if_id_le,
  input  logic              if_id_flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       pc_out,
  output logic [31:0]       npc_out,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc_out,
  output logic              instr_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e state_r;
  logic [31:0]  instr_r;
  logic [31:0]  instr_pc_r;
  logic         instr_valid_r;
  logic         halted_r;
  logic [31:0]  fetch_count_r;

  logic [31:0]  pc_s;
  logic [31:0]  npc_s;
  logic         run_s;
  logic         trap_s;

  assign run_s = (state_r == ST_RUN);

  pc_npc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_npc (
    .clk           (clk),
    .reset         (reset),
    .run_en        (run_s),
    .pc_le         (pc_le),
    .npc_le        (npc_le),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc_s),
    .npc           (npc_s),
    .misalign_trap (trap_s)
  );

  // Fetch FSM together with the IF/ID register it gates
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_START;
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= 32'd0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      case (state_r)
        ST_START: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (trap_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end
          if (if_id_flush) begin
            instr_r       <= NOP_INSTR;
            instr_pc_r    <= pc_s;
            instr_valid_r <= 1'b0;
          end else if (if_id_le) begin
            instr_r       <= imem_data;
            instr_pc_r    <= pc_s;
            instr_valid_r <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
          end
        end
        ST_HALT: begin
          halted_r      <= 1'b1;
          instr_r       <= NOP_INSTR;
          instr_pc_r    <= pc_s;
          instr_valid_r <= 1'b0;
        end
        default: begin
          // Unknown encoding: park safely until the next reset
          state_r       <= ST_HALT;
          halted_r      <= 1'b1;
          instr_r       <= NOP_INSTR;
          instr_pc_r    <= pc_s;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr    = pc_s[ADDR_W-1:0];
  assign pc_out       = pc_s;
  assign npc_out      = npc_s;
  assign instr_out    = instr_r;
  assign instr_pc_out = instr_pc_r;
  assign instr_valid  = instr_valid_r;
  assign halted       = halted_r;
  assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a random
// phase, all compared against a behavioural model of the fetch stage.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_le;
  logic        npc_le;
  logic        if_id_le;
  logic        if_id_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_data;
  logic [8:0]  imem_addr;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Instruction memory: 128 words, combinational read
  logic [31:0] mem [128];
  assign imem_data = mem[imem_addr[8:2]];

  // Behavioural model state (state: 0 = start, 1 = run, 2 = halt)
  int          m_state;
  logic [31:0] m_pc, m_npc, m_ptgt, m_instr, m_ipc, m_count;
  logic        m_pend, m_valid, m_halt;

  if_fetch_unit #(.ADDR_W(9), .RESET_PC(32'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_le         (pc_le),
    .npc_le        (npc_le),
    .if_id_le      (if_id_le),
    .if_id_flush   (if_id_flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .pc_out        (pc_out),
    .npc_out       (npc_out),
    .instr_out     (instr_out),
    .instr_pc_out  (instr_pc_out),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare everything
  task automatic step(input logic r, input logic pl, input logic nl, input logic il,
                      input logic fl, input logic bt, input logic [31:0] tgt);
    logic        eff;
    logic [31:0] et;
    logic [31:0] old_npc;
    reset = r; pc_le = pl; npc_le = nl; if_id_le = il; if_id_flush = fl;
    branch_taken = bt; branch_target = tgt;
    if (!r) begin
      m_state = 0; m_pc = 32'd0; m_npc = 32'd4; m_pend = 1'b0; m_ptgt = 32'd0;
      m_instr = 32'd0; m_ipc = 32'd0; m_valid = 1'b0; m_halt = 1'b0; m_count = 32'd0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      eff = bt || m_pend;
      et  = bt ? tgt : m_ptgt;
      if (fl) begin
        m_instr = 32'd0; m_ipc = m_pc; m_valid = 1'b0;
      end else if (il) begin
        m_instr = mem[m_pc[8:2]]; m_ipc = m_pc; m_valid = 1'b1; m_count = m_count + 32'd1;
      end
      if (eff && (et % 32'd4 != 32'd0)) begin
        m_state = 2; m_halt = 1'b1;
      end else begin
        old_npc = m_npc;
        if (nl) begin
          m_npc  = eff ? et : m_npc + 32'd4;
          m_pend = 1'b0;
        end else if (bt) begin
          m_pend = 1'b1; m_ptgt = tgt;
        end
        if (pl) m_pc = old_npc;
      end
    end else begin
      m_instr = 32'd0; m_valid = 1'b0; m_ipc = m_pc;
    end
    @(posedge clk);
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("npc_out", npc_out, m_npc);
    chk("imem_addr", {23'd0, imem_addr}, {23'd0, m_pc[8:0]});
    chk("instr_out", instr_out, m_instr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_count", fetch_count, m_count);
    if (m_state != 2) chk("instr_pc_out", instr_pc_out, m_ipc);
  endtask

  initial begin
    logic [31:0] saved_count;
    logic [31:0] tgt;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    reset = 1'b0; pc_le = 1'b0; npc_le = 1'b0; if_id_le = 1'b0;
    if_id_flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;

    // Reset state
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_npc", npc_out, 32'd4);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);

    // Straight-line fetch of words 0,4,8 after the START cycle
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("start_hold_pc", pc_out, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("seq_w0", instr_out, mem[0]);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("seq_w4_pc", instr_pc_out, 32'd4);
    // Branch issued at PC=8, nPC=12: delay slot at 12, then 0x40, 0x44
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    chk("seq_w8", instr_out, mem[2]);
    chk("seq_w8_pc", instr_pc_out, 32'd8);
    chk("seq_count3", fetch_count, 32'd3);
    chk("br_slot_pc", pc_out, 32'd12);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("br_tgt_pc", pc_out, 32'h40);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("br_next_pc", pc_out, 32'h44);

    // Redirect parked while nPC is stalled, applied on next nPC load
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    chk("stall_npc", npc_out, 32'h48);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("pend_apply_npc", npc_out, 32'h20);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("pend_clear_npc", npc_out, 32'h24);

    // Flush beats load
    saved_count = m_count;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("flush_instr", instr_out, 32'd0);
    chk("flush_count", fetch_count, saved_count);

    // Random phase with aligned targets and occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) tgt = $urandom & 32'hFFFF_FFFC;
      else tgt = 32'($urandom_range(0, 127)) << 2;
      step(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), tgt);
    end

    // Reset while a redirect is pending discards it
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("rstpend_pc", pc_out, 32'd0);
    chk("rstpend_npc", npc_out, 32'd4);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("rstpend_run_npc", npc_out, 32'd8);

    // Misaligned target halts fetch until reset
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc_out, 32'd4);
    chk("halt_npc", npc_out, 32'd8);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_frozen_pc", pc_out, 32'd4);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("halt_rst_pc", pc_out, 32'd0);
    chk("halt_rst_flag", {31'd0, halted}, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("halt_resume_instr", instr_out, mem[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, instruction-memory byte-address width (512-byte memory).
REQ-002 SHALL have parameter RESET_PC, default 32'd0, PC value loaded at reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low (0 = reset).
REQ-005 SHALL have port pc_le, input, 1, PC load enable from the hazard unit.
REQ-006 SHALL have port npc_le, input, 1, nPC load enable from the hazard unit.
REQ-007 SHALL have port if_id_le, input, 1, IF/ID register load enable.
REQ-008 SHALL have port if_id_flush, input, 1, IF/ID bubble request.
REQ-009 SHALL have port branch_taken, input, 1, redirect request from a resolved branch/jump.
REQ-010 SHALL have port branch_target, input, 32, byte target address.
REQ-011 SHALL have port imem_data, input, 32, instruction word for imem_addr (combinational memory).
REQ-012 SHALL have port imem_addr, output, ADDR_W, equal to pc[ADDR_W-1:0].
REQ-013 SHALL have ports pc_out and npc_out, output, 32 each, current PC and nPC.
REQ-014 SHALL have ports instr_out and instr_pc_out, output, 32 each, IF/ID instruction and its PC.
REQ-015 SHALL have port instr_valid, output, 1, IF/ID holds a real instruction.
REQ-016 SHALL have port halted, output, 1, fetch stopped on a misaligned target.
REQ-017 SHALL have port fetch_count, output, 32, instructions latched valid into IF/ID.

Function
REQ-018 SHALL implement FSM states START, RUN and HALT.
REQ-019 START SHALL last exactly one cycle after reset release, with no PC/nPC/IF-ID update, then go to RUN.
REQ-020 In RUN with pc_le=1, PC SHALL load nPC.
REQ-021 In RUN with npc_le=1, nPC SHALL load the target when a redirect is effective, else nPC+4 (mod 2^32), giving one architectural delay slot.
REQ-022 A redirect SHALL be effective when branch_taken=1 or the pending flag is set; branch_taken input has priority over the pending target.
REQ-023 branch_taken=1 with npc_le=0 SHALL latch branch_target into a pending register, set pending, and apply it on the next npc_le=1 cycle, then clear pending.
REQ-024 A second branch_taken while pending SHALL overwrite the pending target.
REQ-025 pc_le=0 and npc_le=0 SHALL hold PC and nPC unchanged.
REQ-026 An effective target with bits[1:0]!=0 SHALL move the FSM to HALT instead of loading nPC; PC, nPC and pending SHALL hold, and halted SHALL assert next cycle.
REQ-027 HALT SHALL be left only by reset; in HALT, IF/ID SHALL load NOP (32'd0) with instr_valid=0 every cycle.
REQ-028 In RUN with if_id_flush=1, IF/ID SHALL load instr=0, instr_pc=PC and valid=0; flush overrides if_id_le.
REQ-029 In RUN with if_id_le=1 and no flush, IF/ID SHALL load imem_data, PC and valid=1, and fetch_count SHALL increment (wraps at 2^32).
REQ-030 if_id_le=0 and no flush SHALL hold IF/ID contents.
REQ-031 Latency SHALL be: imem_data sampled at PC p appears on instr_out one cycle later.

Reset
REQ-032 On reset=0 at a clock edge: PC=RESET_PC, nPC=RESET_PC+4, pending=0, pending target=0, instr_out=0, instr_pc_out=0, instr_valid=0, halted=0, fetch_count=0, FSM=START.
REQ-033 Reset asserted mid-operation, including in HALT or with a pending redirect, SHALL discard all state on that edge.

Structure
REQ-034 FSM state encoding, the NOP constant and default RESET_PC SHALL live in shared package pipeline_pkg.
REQ-035 The PC/nPC pair plus pending-target logic SHALL be one sub-module, pc_npc_unit; the IF/ID register and FSM SHALL stay in the top.

Verification
REQ-036 Reset released, all LEs=1, memory words at 0,4,8 -> after START, instr_out sequence word0, word4, word8 with instr_pc_out 0,4,8; fetch_count=3.
REQ-037 At PC=8, nPC=12, branch_taken=1, target=0x40 -> PC sequence 8, 12, 0x40, 0x44 (delay slot at 12 fetched).
REQ-038 branch_taken=1, target=0x20 while npc_le=0 for 2 cycles, then npc_le=1 -> nPC=0x20 on that edge; pending clears.
REQ-039 if_id_flush=1 with if_id_le=1 -> instr_out=0, instr_valid=0, fetch_count unchanged.
REQ-040 branch_taken=1, target=0x22 -> halted=1 next cycle, PC/nPC frozen, instr_valid=0 until reset=0, then PC=0, halted=0.
REQ-041 reset=0 asserted for one cycle while pending=1 -> PC=0, nPC=4, pending target never applied.
